rx_pipe: RTL

RX_PIPE -- requirements
Module: rx_pipe

---
 rtl/rx_pipe.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rx_pipe.sv
// rx_pipe: 2-phase channel receiver feeding a packet FIFO, with a 4-phase
// switch-request FSM on the transmit side.
module rx_pipe #(
  parameter int ID           = 0,
  parameter int SIZE         = 8,
  parameter int CHANNEL_BITS = 3,
  parameter int BUFF_BITS    = 4,
  parameter int PKT_FLITS    = 8,
  parameter int ROUTE_MODE   = 0,
  parameter int DESTINATION  = 0,
  parameter int DEST_LSB     = 0,
  parameter int CUT_THROUGH  = 0,
  parameter int SINK_PACKETS = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ch_req,
  input  logic [SIZE-1:0]         ch_flit,
  output logic                    ch_ack,
  output logic                    sw_req,
  output logic [CHANNEL_BITS-1:0] sw_chnl,
  input  logic                    sw_gnt,
  output logic [SIZE-1:0]         out_flit,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BUFF_BITS:0]      fifo_cnt,
  output logic                    proto_err
);

  localparam int unsigned DEPTH = 1 << BUFF_BITS;
  localparam int CNT_W = BUFF_BITS + 1;
  localparam int IDX_W = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_FLITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_SEND, TX_REL} tx_state_e;

  logic [SIZE-1:0]         mem_q [DEPTH];
  logic [BUFF_BITS-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, pkts_q, pkts_d;
  logic [IDX_W-1:0]        rx_idx_q, rx_idx_d, tx_idx_q, tx_idx_d;
  logic                    ch_ack_q, ch_ack_d, proto_err_q, proto_err_d;
  logic                    sw_req_q, sw_req_d;
  logic [CHANNEL_BITS-1:0] sw_chnl_q, sw_chnl_d, head_chnl;
  tx_state_e               state_q, state_d;

  logic accept, drop, misplaced, wr_en, rx_last, pop, pop_last, tx_start;
  logic unused_id;

  assign unused_id = (ID != 0);

  always_comb begin
    accept    = (ch_req != ch_ack_q) && (cnt_q != FULL_CNT);
    drop      = accept && (rx_idx_q == '0) && !ch_flit[SIZE-1];
    misplaced = accept && (rx_idx_q != '0) && ch_flit[SIZE-1];
    wr_en     = accept && !drop;
    rx_last   = wr_en && (rx_idx_q == LAST_IDX);

    out_flit = mem_q[rd_ptr_q];
    if (ROUTE_MODE != 0) head_chnl = out_flit[DEST_LSB +: CHANNEL_BITS];
    else                 head_chnl = CHANNEL_BITS'(DESTINATION);

    // sink mode drains whole packets locally, one flit per cycle
    if (SINK_PACKETS != 0) begin
      pop       = (pkts_q != '0);
      out_valid = 1'b0;
      tx_start  = 1'b0;
    end else begin
      out_valid = (state_q == TX_SEND) && (cnt_q != '0);
      pop       = out_valid && out_ready;
      if (CUT_THROUGH != 0) tx_start = !sw_gnt && (cnt_q != '0);
      else                  tx_start = !sw_gnt && (pkts_q != '0);
    end
    pop_last = pop && (tx_idx_q == LAST_IDX);

    ch_ack_d    = accept ? !ch_ack_q : ch_ack_q;
    proto_err_d = drop || misplaced;
    wr_ptr_d    = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d       = cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
    pkts_d      = pkts_q + CNT_W'(rx_last) - CNT_W'(pop_last);

    rx_idx_d = rx_idx_q;
    if (wr_en) rx_idx_d = rx_last ? '0 : rx_idx_q + 1'b1;
    tx_idx_d = tx_idx_q;
    if (pop) tx_idx_d = pop_last ? '0 : tx_idx_q + 1'b1;

    state_d   = state_q;
    sw_req_d  = sw_req_q;
    sw_chnl_d = sw_chnl_q;
    unique case (state_q)
      TX_IDLE: if (tx_start) begin
        state_d   = TX_REQ;
        sw_req_d  = 1'b1;
        sw_chnl_d = head_chnl;
      end
      TX_REQ:  if (sw_gnt) state_d = TX_SEND;
      TX_SEND: if (pop_last) begin
        state_d  = TX_REL;
        sw_req_d = 1'b0;
      end
      TX_REL:  if (!sw_gnt) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= ch_flit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      pkts_q      <= '0;
      rx_idx_q    <= '0;
      tx_idx_q    <= '0;
      ch_ack_q    <= 1'b0;
      proto_err_q <= 1'b0;
      sw_req_q    <= 1'b0;
      sw_chnl_q   <= '0;
      state_q     <= TX_IDLE;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      pkts_q      <= pkts_d;
      rx_idx_q    <= rx_idx_d;
      tx_idx_q    <= tx_idx_d;
      ch_ack_q    <= ch_ack_d;
      proto_err_q <= proto_err_d;
      sw_req_q    <= sw_req_d;
      sw_chnl_q   <= sw_chnl_d;
      state_q     <= state_d;
    end
  end

  assign ch_ack    = ch_ack_q;
  assign proto_err = proto_err_q;
  assign sw_req    = sw_req_q;
  assign sw_chnl   = sw_chnl_q;
  assign fifo_cnt  = cnt_q;

endmodule
